// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
package mips_fetch_pkg;

   // ISSUE: may start a fetch; WAIT: fetch in flight, result kept;
   // DRAIN: fetch in flight on the wrong path, result dropped.
   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
   localparam int          PC_STEP   = 4;

endpackage : mips_fetch_pkg

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory over a
// req/ack handshake and presents each instruction to decode.
//
// Handshakes:
//   memory side : imem_req stays high until the cycle imem_ack is seen
//                 (rdata valid in that cycle); only reset withdraws it.
//   decode side : the entry transfers on a cycle with instr_valid and
//                 instr_ready both high; instr* hold steady otherwise.
module instr_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [5:0]        opcode,
   output logic [5:0]        funct,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] pc_plus4,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall,
   output fetch_state_t      dbg_state_o
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic              valid_q;
   logic [DATA_W-1:0] instr_q;
   logic [ADDR_W-1:0] instr_pc_q;

   logic slot_free;
   logic capture;

   assign slot_free = !valid_q || instr_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ISSUE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a redirect without ack turns an in-flight fetch into a drain
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ISSUE: if (imem_req && !imem_ack) state_d = WAIT;
         WAIT: begin
            if (imem_ack)            state_d = ISSUE;
            else if (redirect_valid) state_d = DRAIN;
         end
         DRAIN: if (imem_ack) state_d = ISSUE;
         default: state_d = ISSUE;
      endcase
   end

   // Outputs: request and the capture strobe shared with the output register
   always_comb begin
      imem_req = 1'b0;
      capture  = 1'b0;
      unique case (state_q)
         ISSUE: begin
            imem_req = rst_n && !stall && slot_free && !redirect_valid;
            capture  = imem_req && imem_ack;
         end
         WAIT: begin
            imem_req = 1'b1;
            capture  = imem_ack && !redirect_valid;
         end
         DRAIN: begin
            imem_req = 1'b1;
            capture  = 1'b0;
         end
         default: begin
            imem_req = 1'b0;
            capture  = 1'b0;
         end
      endcase
   end

   // PC and output register; redirect beats capture, capture beats consume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         instr_q    <= DATA_W'(INSTR_NOP);
         instr_pc_q <= '0;
      end else begin
         if (redirect_valid) begin
            pc_q    <= redirect_pc & ~ADDR_W'(3);
            valid_q <= 1'b0;
         end else if (capture) begin
            pc_q    <= pc_q + ADDR_W'(PC_STEP);
            valid_q <= 1'b1;
         end else if (instr_ready) begin
            valid_q <= 1'b0;
         end
         if (capture) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
         end
      end
   end

   assign imem_addr   = pc_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
   assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
   assign pc_plus4    = instr_pc_q + ADDR_W'(PC_STEP);
   assign dbg_state_o = state_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a random phase,
// with a memory model and a program-order model of the decode stream.
module tb_instr_fetch_unit;
   import mips_fetch_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         imem_req;
   logic [31:0]  imem_addr;
   logic         imem_ack;
   logic [31:0]  imem_rdata;
   logic         instr_valid;
   logic         instr_ready;
   logic [31:0]  instr;
   logic [5:0]   opcode;
   logic [5:0]   funct;
   logic [31:0]  instr_pc;
   logic [31:0]  pc_plus4;
   logic         redirect_valid;
   logic [31:0]  redirect_pc;
   logic         stall;
   fetch_state_t dbg_state;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .opcode         (opcode),
      .funct          (funct),
      .instr_pc       (instr_pc),
      .pc_plus4       (pc_plus4),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .dbg_state_o    (dbg_state)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Memory image: explicit words where set, otherwise a hash of the address
   logic [31:0] mem_ov [logic [31:0]];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_ov.exists(a)) return mem_ov[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   // Reference model of the decode stream and memory timing
   logic [31:0] exp_pc;
   bit          outstanding;
   logic [31:0] prev_addr;
   bit          prev_rv;
   bit          prev_hold;
   logic [31:0] prev_ipc;
   logic [31:0] prev_instr;
   int          wait_cnt;
   int          cur_lat;
   int          fixed_lat;
   bit          lat_rand;
   logic [31:0] s_addr;
   bit          s_req;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs at negedge, answer the memory, check
   // before the rising edge, then advance the model past the edge.
   task automatic step(input bit st, input bit rdy, input bit rv, input logic [31:0] rpc);
      logic [31:0] exp_w;
      bit          s_ack, s_valid;
      @(negedge clk);
      stall          = st;
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_ack       = 1'b0;
      #1;
      if (imem_req && wait_cnt >= cur_lat) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_word(imem_addr);
      end else begin
         imem_rdata = $urandom;
      end
      #1;
      s_req   = imem_req;
      s_ack   = imem_ack;
      s_addr  = imem_addr;
      s_valid = instr_valid;
      if (s_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (outstanding) begin
         check("req_held", 32'(imem_req), 32'd1);
         if (!prev_rv) check("addr_held", imem_addr, prev_addr);
      end else begin
         check("req_issue", 32'(imem_req), 32'(!st && (!instr_valid || rdy) && !rv));
      end
      if (prev_hold) begin
         check("hold_valid", 32'(instr_valid), 32'd1);
         check("hold_pc", instr_pc, prev_ipc);
         check("hold_instr", instr, prev_instr);
      end
      if (instr_valid && rdy) begin
         exp_w = mem_word(exp_pc);
         check("cons_pc", instr_pc, exp_pc);
         check("cons_instr", instr, exp_w);
         check("cons_opcode", 32'(opcode), 32'(exp_w[31:26]));
         check("cons_funct", 32'(funct), 32'(exp_w[5:0]));
         check("cons_pc4", pc_plus4, exp_pc + 32'd4);
      end
      @(posedge clk);
      if (s_valid && rdy) exp_pc = exp_pc + 32'd4;
      if (rv) exp_pc = rpc & 32'hFFFF_FFFC;
      outstanding = s_req && !s_ack;
      prev_addr   = s_addr;
      prev_rv     = rv;
      prev_hold   = s_valid && !rdy && !rv;
      prev_ipc    = instr_pc;
      prev_instr  = instr;
      if (s_req && s_ack) begin
         wait_cnt = 0;
         cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : fixed_lat;
      end else if (s_req) begin
         wait_cnt++;
      end
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      stall          = 1'b0;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_ack       = 1'b0;
      imem_rdata     = '0;
      exp_pc         = 32'h0000_0000;
      outstanding    = 0;
      prev_addr      = '0;
      prev_rv        = 0;
      prev_hold      = 0;
      prev_ipc       = '0;
      prev_instr     = '0;
      wait_cnt       = 0;
      cur_lat        = 0;
      fixed_lat      = 0;
      lat_rand       = 0;
      mem_ov[32'h0000_0000] = 32'h8C22_0004;
      mem_ov[32'h0000_0004] = 32'h0000_0020;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_ipc", instr_pc, 32'd0);
      check("rst_addr", imem_addr, 32'h0000_0000);
      check("rst_state", 32'(dbg_state), 32'(ISSUE));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Zero-wait memory: one fetch per cycle, lw then add decoded
      step(0, 1, 0, '0);
      check("zw_addr0", s_addr, 32'h0);
      check("zw_req0", 32'(s_req), 32'd1);
      check("lw_opcode", 32'(opcode), 32'h23);
      check("lw_pc", instr_pc, 32'h0);
      step(0, 1, 0, '0);
      check("zw_addr1", s_addr, 32'h4);
      check("add_opcode", 32'(opcode), 32'h0);
      check("add_funct", 32'(funct), 32'h20);
      step(0, 1, 0, '0);
      check("zw_addr2", s_addr, 32'h8);
      check("zw_valid2", 32'(instr_valid), 32'd1);
      step(0, 1, 0, '0);
      check("zw_addr3", s_addr, 32'hC);
      check("zw_ipc3", instr_pc, 32'hC);

      // Slow memory, redirect in the second WAIT cycle drains the fetch
      fixed_lat = 3;
      cur_lat   = 3;
      step(0, 1, 0, '0);
      check("slow_addr", s_addr, 32'h10);
      step(0, 1, 0, '0);
      step(0, 1, 1, 32'h0000_0100);
      check("drain_state", 32'(dbg_state), 32'(DRAIN));
      check("drain_addr", imem_addr, 32'h100);
      check("drain_valid", 32'(instr_valid), 32'd0);
      fixed_lat = 0;
      step(0, 1, 0, '0);
      check("drop_valid", 32'(instr_valid), 32'd0);
      check("drop_state", 32'(dbg_state), 32'(ISSUE));
      step(0, 1, 0, '0);
      check("redir_addr", s_addr, 32'h100);
      check("redir_ipc", instr_pc, 32'h100);

      // Decode back-pressure for five cycles
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, '0);
         check("bp_req", 32'(s_req), 32'd0);
         check("bp_ipc", instr_pc, 32'h100);
      end
      step(0, 1, 0, '0);
      check("bp_resume_req", 32'(s_req), 32'd1);
      check("bp_resume_addr", s_addr, 32'h104);

      // Stall raised while a fetch waits: it completes, then nothing issues
      cur_lat   = 2;
      fixed_lat = 0;
      step(0, 1, 0, '0);
      check("st_addr", s_addr, 32'h108);
      step(1, 1, 0, '0);
      check("st_wait_req", 32'(s_req), 32'd1);
      step(1, 1, 0, '0);
      check("st_cap_ipc", instr_pc, 32'h108);
      check("st_cap_valid", 32'(instr_valid), 32'd1);
      step(1, 1, 0, '0);
      check("st_noreq0", 32'(s_req), 32'd0);
      step(1, 1, 0, '0);
      check("st_noreq1", 32'(s_req), 32'd0);
      step(0, 1, 0, '0);
      check("st_release_addr", s_addr, 32'h10C);

      // Unaligned redirect at the top of memory and PC wrap
      step(0, 1, 1, 32'hFFFF_FFFE);
      check("wrap_noreq", 32'(s_req), 32'd0);
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      step(0, 1, 0, '0);
      check("wrap_fetch", s_addr, 32'hFFFF_FFFC);
      check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
      check("wrap_pc4", pc_plus4, 32'h0);
      step(0, 1, 0, '0);
      check("wrap_next", s_addr, 32'h0);
      check("wrap_next_pc4", pc_plus4, 32'h4);

      // Random phase
      lat_rand = 1;
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] rpc;
         rpc = $urandom;
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
         step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0, rpc);
      end

      // Asynchronous reset in the middle of a cycle
      step(0, 0, 0, '0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(instr_valid), 32'd0);
      check("arst_req", 32'(imem_req), 32'd0);
      check("arst_addr", imem_addr, 32'h0);
      check("arst_state", 32'(dbg_state), 32'(ISSUE));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_instr_fetch_unit
